alu_multicycle: RTL and testbench

//  Parametrised multi-cycle ALU for the processor datapath. It executes the existing 4-bit opcode set over WIDTH bits.
//  MUL and DIV run as iterative shift-add / restoring-divide engines instead of combinational operators.

---
 rtl/alu_multicycle.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: WIDTH-bit ALU with a valid/ready handshake on both sides.
// Single-cycle ops (0-13) resolve in one pass. MUL (14) runs as an iterative
// shift-add engine and DIV (15) as a restoring divider, one bit per cycle.
// Results and flags are registered and held until the consumer accepts them.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new op; in_ready=1
// MUL   | shift-add iteration, one multiplier bit per cycle
// DIV   | restoring-divide iteration, one quotient bit per cycle
// DONE  | result/flags valid, out_valid=1, waiting for out_ready
module alu_multicycle #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             div_zero
);

  localparam logic [3:0]     OP_ADD  = 4'd0;
  localparam logic [3:0]     OP_SUB  = 4'd1;
  localparam logic [3:0]     OP_AND  = 4'd2;
  localparam logic [3:0]     OP_OR   = 4'd3;
  localparam logic [3:0]     OP_XOR  = 4'd4;
  localparam logic [3:0]     OP_NOR  = 4'd5;
  localparam logic [3:0]     OP_SLL  = 4'd6;
  localparam logic [3:0]     OP_SRL  = 4'd7;
  localparam logic [3:0]     OP_SRA  = 4'd8;
  localparam logic [3:0]     OP_SLTU = 4'd9;
  localparam logic [3:0]     OP_PB   = 4'd10;
  localparam logic [3:0]     OP_PA   = 4'd11;
  localparam logic [3:0]     OP_NA   = 4'd12;
  localparam logic [3:0]     OP_NB   = 4'd13;
  localparam logic [3:0]     OP_MUL  = 4'd14;
  localparam logic [3:0]     OP_DIV  = 4'd15;

  // iteration timer counts down from WIDTH-1; the step taken at zero is the last
  localparam logic [SHW-1:0] CNT_LOAD = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // iteration registers: acc is product accumulator / partial remainder,
  // opa is multiplicand / quotient shift register, opb is multiplier / divisor
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [SHW-1:0]   cnt;

  logic             is_mul;
  logic             is_div;
  logic             b_zero;
  logic             start_iter;
  logic             cnt_tc;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_dz;

  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;

  logic             res_load;
  logic [WIDTH-1:0] res_val;
  logic             res_c;
  logic             res_v;
  logic             res_dz;

  assign is_mul     = (op == OP_MUL);
  assign is_div     = (op == OP_DIV);
  assign b_zero     = (B == '0);
  assign start_iter = is_mul || (is_div && !b_zero);
  assign cnt_tc     = (cnt == '0);

  assign shamt   = B[SHW-1:0];
  assign add_ext = {1'b0, A} + {1'b0, B};
  assign sub_ext = {1'b0, A} - {1'b0, B};

  // one shift-add step
  assign mul_acc_nxt = opb[0] ? (acc + opa) : acc;

  // one restoring-divide step; the trial is one bit wider so a shifted
  // remainder up to 2*B-1 still compares correctly
  assign div_trial   = {acc, opa[WIDTH-1]} - {1'b0, opb};
  assign div_ge      = ~div_trial[WIDTH];
  assign div_rem_nxt = div_ge ? div_trial[WIDTH-1:0] : {acc[WIDTH-2:0], opa[WIDTH-1]};
  assign div_quo_nxt = {opa[WIDTH-2:0], div_ge};

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mul) begin
            state_nxt = S_MUL;
          end else if (is_div && !b_zero) begin
            state_nxt = S_DIV;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_MUL: begin
        if (cnt_tc) state_nxt = S_DONE;
      end
      S_DIV: begin
        if (cnt_tc) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // single-cycle ALU operations on the live operands
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_dz  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = ~sub_ext[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SLL:  alu_res = A << shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(A) >>> shamt);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_PB:   alu_res = B;
      OP_PA:   alu_res = A;
      OP_NA:   alu_res = ~A;
      OP_NB:   alu_res = ~B;
      OP_DIV: begin
        // only reaches the result register when B is zero
        alu_res = '1;
        alu_dz  = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  // select which source, if any, loads the result register this cycle
  always_comb begin
    res_load = 1'b0;
    res_val  = alu_res;
    res_c    = 1'b0;
    res_v    = 1'b0;
    res_dz   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && !start_iter) begin
          res_load = 1'b1;
          res_val  = alu_res;
          res_c    = alu_c;
          res_v    = alu_v;
          res_dz   = alu_dz;
        end
      end
      S_MUL: begin
        if (cnt_tc) begin
          res_load = 1'b1;
          res_val  = mul_acc_nxt;
        end
      end
      S_DIV: begin
        if (cnt_tc) begin
          res_load = 1'b1;
          res_val  = div_quo_nxt;
        end
      end
      default: res_load = 1'b0;
    endcase
  end

  // operand capture and MUL/DIV iteration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      opa <= '0;
      opb <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && start_iter) begin
            acc <= '0;
            opa <= A;
            opb <= B;
            cnt <= CNT_LOAD;
          end
        end
        S_MUL: begin
          acc <= mul_acc_nxt;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt - 1'b1;
        end
        S_DIV: begin
          acc <= div_rem_nxt;
          opa <= div_quo_nxt;
          cnt <= cnt - 1'b1;
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

  // registered result and flags, held until the next op completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result     <= '0;
      zero_flag  <= 1'b0;
      neg_flag   <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      div_zero   <= 1'b0;
    end else if (res_load) begin
      result     <= res_val;
      zero_flag  <= (res_val == '0);
      neg_flag   <= res_val[WIDTH-1];
      carry_flag <= res_c;
      ovf_flag   <= res_v;
      div_zero   <= res_dz;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle (WIDTH=64): directed vector table, handshake
// corner sequences, and randomized ops checked against an arithmetic model.
module tb_alu_multicycle;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    logic        dz;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a_in = '0;
  logic [63:0] b_in = '0;
  logic [3:0]  op_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        zero_flag, neg_flag, carry_flag, ovf_flag, div_zero;

  int n_total = 0;
  int n_pass  = 0;

  alu_multicycle #(.WIDTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (a_in),
    .B          (b_in),
    .op         (op_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // reference model: results from plain arithmetic on the opcode definitions
  function automatic vec_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    vec_t m;
    logic signed [64:0] s;
    logic [5:0] sh;
    sh = b[5:0];
    m.op = op; m.a = a; m.b = b;
    m.r = '0; m.c = 1'b0; m.v = 1'b0; m.dz = 1'b0; m.lat = 1;
    case (op)
      4'd0: begin
        m.r = a + b;
        m.c = ({1'b0, a} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
        s = $signed({a[63], a}) + $signed({b[63], b});
        m.v = (s > 65'sd9223372036854775807) || (s < -65'sd9223372036854775808);
      end
      4'd1: begin
        m.r = a - b;
        m.c = (a >= b);
        s = $signed({a[63], a}) - $signed({b[63], b});
        m.v = (s > 65'sd9223372036854775807) || (s < -65'sd9223372036854775808);
      end
      4'd2:  m.r = a & b;
      4'd3:  m.r = a | b;
      4'd4:  m.r = a ^ b;
      4'd5:  m.r = ~(a | b);
      4'd6:  m.r = a << sh;
      4'd7:  m.r = a >> sh;
      4'd8:  m.r = $signed(a) >>> sh;
      4'd9:  m.r = (a < b) ? 64'd1 : 64'd0;
      4'd10: m.r = b;
      4'd11: m.r = a;
      4'd12: m.r = ~a;
      4'd13: m.r = ~b;
      4'd14: begin m.r = a * b; m.lat = 65; end
      default: begin
        if (b == 0) begin m.r = '1; m.dz = 1'b1; m.lat = 1; end
        else begin m.r = a / b; m.lat = 65; end
      end
    endcase
    m.z = (m.r == 0);
    m.n = m.r[63];
    return m;
  endfunction

  // issue one op, wait for completion, accept it; reports observed outputs
  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        output vec_t obs, output bit busy_ok, output bit drop_ok);
    int n;
    int w;
    busy_ok = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    op_in = o; a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (in_ready) busy_ok = 1'b0;
    obs.op = o; obs.a = a; obs.b = b;
    obs.r = result; obs.c = carry_flag; obs.v = ovf_flag;
    obs.z = zero_flag; obs.n = neg_flag; obs.dz = div_zero;
    obs.lat = out_valid ? n : -1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drop_ok = !out_valid && in_ready;
  endtask

  task automatic cmp_vec(input string tag, input vec_t e, input vec_t g, input bit busy_ok, input bit drop_ok);
    chk($sformatf("%s result", tag), g.r, e.r);
    chk($sformatf("%s flags{c,v,z,n,dz}", tag), 64'({g.c, g.v, g.z, g.n, g.dz}),
        64'({e.c, e.v, e.z, e.n, e.dz}));
    chk($sformatf("%s latency", tag), 64'(g.lat), 64'(e.lat));
    chk($sformatf("%s in_ready low while busy", tag), 64'(busy_ok), 64'd1);
    chk($sformatf("%s out_valid drops after accept", tag), 64'(drop_ok), 64'd1);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t obs;
    vec_t exp_v;
    bit   busy_ok, drop_ok, hold_ok, pulse_seen;
    int   w;
    logic [3:0]  r_op;
    logic [63:0] r_a, r_b;

    // op, a, b, result, c, v, z, n, dz, latency
    vecs.push_back('{4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd1,  64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd14, 64'd123456789, 64'd1000, 64'd123456789000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 65});
    vecs.push_back('{4'd15, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 65});
    vecs.push_back('{4'd15, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{4'd8,  64'hF000_0000_0000_0000, 64'h104, 64'hFF00_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd1,  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd9,  64'd3, 64'd5, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd6,  64'd1, 64'h7F, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd5,  64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd0,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd7,  64'h8000_0000_0000_0000, 64'h41, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd4,  64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 65});
    vecs.push_back('{4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 65});
    vecs.push_back('{4'd2,  64'hC, 64'hA, 64'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd10, 64'd1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd12, 64'd0, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd13, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd11, 64'd5, 64'd77, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});

    // reset state
    repeat (3) @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset flags", 64'({carry_flag, ovf_flag, zero_flag, neg_flag, div_zero}), 64'd0);
    reset = 1'b0;

    // directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, obs, busy_ok, drop_ok);
      cmp_vec($sformatf("vec%0d", i), vecs[i], obs, busy_ok, drop_ok);
    end

    // result held while out_ready stays low; in_valid in DONE is ignored
    @(negedge clk);
    op_in = 4'd0; a_in = 64'd10; b_in = 64'd20; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin @(negedge clk); w++; end
    hold_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; op_in = 4'd11; a_in = {$urandom, $urandom} | 64'h1; b_in = 64'd1;
      @(negedge clk);
      if (!out_valid || result !== 64'd30 || in_ready) hold_ok = 1'b0;
    end
    in_valid = 1'b0;
    chk("hold in DONE stable", 64'(hold_ok), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold release out_valid", 64'(out_valid), 64'd0);
    repeat (3) @(negedge clk);
    chk("ignored in_valid not queued", 64'({out_valid, in_ready}), 64'b01);
    chk("hold result kept", result, 64'd30);

    // reset in the middle of a multiply discards it
    op_in = 4'd14; a_in = 64'h1234_5678_9ABC_DEF1; b_in = 64'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid-MUL reset in_ready", 64'(in_ready), 64'd1);
    chk("mid-MUL reset out_valid", 64'(out_valid), 64'd0);
    chk("mid-MUL reset result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulse_seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) pulse_seen = 1'b1;
    end
    chk("aborted MUL no out_valid", 64'(pulse_seen), 64'd0);
    run_op(4'd0, 64'd2, 64'd3, obs, busy_ok, drop_ok);
    cmp_vec("post-reset ADD", model(4'd0, 64'd2, 64'd3), obs, busy_ok, drop_ok);

    // randomized ops against the model
    for (int t = 0; t < 150; t++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       r_b = 64'd0;
        1:       r_b = 64'($urandom_range(1, 300));
        2:       r_b = {32'd0, $urandom};
        default: r_b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 4) == 0) r_a = r_b;
      exp_v = model(r_op, r_a, r_b);
      run_op(r_op, r_a, r_b, obs, busy_ok, drop_ok);
      cmp_vec($sformatf("rnd%0d op%0d", t, r_op), exp_v, obs, busy_ok, drop_ok);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
